req_pending_ctrl_v: RTL and testbench

//  Upstream stage of the 4:2 priority encoder. Captures events on 4 request lines into sticky pending bits.

---
 rtl/req_pending_pkg.sv | 21 ++
 rtl/priority_enc_4_2_v.sv | 24 ++
 rtl/req_pending_ctrl_v.sv | 122 ++++++++++++
 tb/tb_req_pending_ctrl_v.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_pending_pkg.sv
// Shared types and constants for the request-pending controller.
// Holds request count, index width, FSM encoding and a one-hot helper.
package req_pending_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] idx_onehot(
        input logic [IDX_W-1:0] idx
    );
        logic [N_REQ-1:0] one;
        one = {{(N_REQ-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/priority_enc_4_2_v.sv
// 4:2 priority encoder, bit 3 has the highest priority.
// o_valid is the OR of all inputs; o_code is 0 when nothing is set.
module priority_enc_4_2_v
    import req_pending_pkg::*;
(
    input  logic [N_REQ-1:0] i_code,
    output logic [IDX_W-1:0] o_code,
    output logic             o_valid
);

    // Highest set bit wins
    always_comb begin
        o_code  = '0;
        o_valid = |i_code;
        priority case (1'b1)
            i_code[3]: o_code = 2'd3;
            i_code[2]: o_code = 2'd2;
            i_code[1]: o_code = 2'd1;
            i_code[0]: o_code = 2'd0;
            default:   o_code = 2'd0;
        endcase
    end

endmodule

// File: rtl/req_pending_ctrl_v.sv
// Sticky request capture feeding a priority encoder, grant offered on valid/ready.
// Optional macro REQ_MASK_EN adds i_mask to hide pending bits from the encoder.
module req_pending_ctrl_v
    import req_pending_pkg::*;
#(
    parameter bit DETECT_EDGE = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
`ifdef REQ_MASK_EN
    input  logic [N_REQ-1:0] i_mask,
`endif
    output logic             o_gnt_valid,
    output logic [IDX_W-1:0] o_gnt_idx,
    input  logic             i_gnt_ready,
    output logic [N_REQ-1:0] o_pending,
    output logic [N_REQ-1:0] o_drop,
    input  logic             i_drop_clr,
    output logic [CNT_W-1:0] o_gnt_cnt
);

    state_t           state;
    state_t           state_nx;
    logic [N_REQ-1:0] req_d;
    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] drop;
    logic [IDX_W-1:0] gnt_idx;
    logic [CNT_W-1:0] gnt_cnt;
    logic [N_REQ-1:0] cap;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] drop_set;
    logic [N_REQ-1:0] enc_in;
    logic [IDX_W-1:0] enc_code;
    logic             enc_valid;
    logic             accept;
    logic             load_idx;
    logic             offer;

    assign cap      = DETECT_EDGE ? (i_req & ~req_d) : i_req;
    assign clr      = accept ? idx_onehot(gnt_idx) : '0;
    assign drop_set = cap & pending & ~clr;

`ifdef REQ_MASK_EN
    assign enc_in = pending & ~i_mask;
`else
    assign enc_in = pending;
`endif

    priority_enc_4_2_v u_enc (
        .i_code  (enc_in),
        .o_code  (enc_code),
        .o_valid (enc_valid)
    );

    // Next state and handshake decode; the offered index is frozen in OFFER
    always_comb begin
        state_nx = state;
        offer    = 1'b0;
        load_idx = 1'b0;
        accept   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enc_valid) begin
                    load_idx = 1'b1;
                    state_nx = ST_OFFER;
                end
            end
            ST_OFFER: begin
                offer = 1'b1;
                if (i_gnt_ready) begin
                    accept   = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Latch the encoder winner when an offer starts
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)      gnt_idx <= '0;
        else if (load_idx) gnt_idx <= enc_code;
    end

    // Edge history and sticky pending; a new capture beats a same-cycle clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            req_d   <= '0;
            pending <= '0;
        end else begin
            req_d   <= i_req;
            pending <= (pending & ~clr) | cap;
        end
    end

    // Overflow flags; a set in the clearing cycle survives
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) drop <= '0;
        else          drop <= (i_drop_clr ? '0 : drop) | drop_set;
    end

    // Accepted-grant counter, wraps silently
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)    gnt_cnt <= '0;
        else if (accept) gnt_cnt <= gnt_cnt + CNT_W'(1);
    end

    assign o_gnt_valid = offer;
    assign o_gnt_idx   = gnt_idx;
    assign o_pending   = pending;
    assign o_drop      = drop;
    assign o_gnt_cnt   = gnt_cnt;

endmodule

// File: tb/tb_req_pending_ctrl_v.sv
// Self-checking bench for req_pending_ctrl_v.
// Grant indices are queued when stimulus is driven and compared on accept.
module tb_req_pending_ctrl_v;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic       gnt_ready;
    logic [3:0] pending;
    logic [3:0] drop;
    logic       drop_clr;
    logic [7:0] gnt_cnt;
`ifdef REQ_MASK_EN
    logic [3:0] mask;
`endif

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    req_pending_ctrl_v #(.DETECT_EDGE(1'b1), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
`ifdef REQ_MASK_EN
        .i_mask      (mask),
`endif
        .o_gnt_valid (gnt_valid),
        .o_gnt_idx   (gnt_idx),
        .i_gnt_ready (gnt_ready),
        .o_pending   (pending),
        .o_drop      (drop),
        .i_drop_clr  (drop_clr),
        .o_gnt_cnt   (gnt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every accepted grant must match the next queued index
    always @(negedge clk) begin
        if (rst_n && gnt_valid && gnt_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL grant_unexpected got idx=%0d want none", gnt_idx);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (gnt_idx !== e) begin
                    errors++;
                    $display("FAIL grant_idx got %0d want %0d", gnt_idx, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s timeout left %0d want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        gnt_ready = 1'b0;
        drop_clr  = 1'b0;
        req       = 4'b0000;
`ifdef REQ_MASK_EN
        mask      = 4'b0000;
`endif
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        gnt_ready = 1'b0;
        drop_clr  = 1'b0;
        req       = 4'b1010;
`ifdef REQ_MASK_EN
        mask      = 4'b0000;
`endif
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {7'd0, gnt_valid}, 8'd0);
        chk("rst_idx", {6'd0, gnt_idx}, 8'd0);
        chk("rst_pending", {4'd0, pending}, 8'd0);
        chk("rst_drop", {4'd0, drop}, 8'd0);
        chk("rst_cnt", gnt_cnt, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_pending", {4'd0, pending}, 8'h0a);
        chk("rel_valid", {7'd0, gnt_valid}, 8'd0);
        tick();
        chk("rel_valid2", {7'd0, gnt_valid}, 8'd1);
        chk("rel_idx", {6'd0, gnt_idx}, 8'd3);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        gnt_ready = 1'b1;
        drain("rel_drain", 20);
        tick();
        chk("rel_cnt", gnt_cnt, 8'd2);
        chk("rel_pend0", {4'd0, pending}, 8'd0);
    endtask

    task automatic test_single();
        do_reset();
        gnt_ready = 1'b1;
        exp_q.push_back(2'd2);
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("sgl_pending", {4'd0, pending}, 8'h04);
        chk("sgl_early", {7'd0, gnt_valid}, 8'd0);
        tick();
        chk("sgl_valid", {7'd0, gnt_valid}, 8'd1);
        chk("sgl_idx", {6'd0, gnt_idx}, 8'd2);
        tick();
        chk("sgl_pend0", {4'd0, pending}, 8'd0);
        chk("sgl_cnt", gnt_cnt, 8'd1);
        chk("sgl_idle", {7'd0, gnt_valid}, 8'd0);
        drain("sgl_drain", 2);
    endtask

    task automatic test_priority();
        do_reset();
        req = 4'b0011;
        tick();
        req = 4'b0000;
        tick();
        chk("pri_idx1", {6'd0, gnt_idx}, 8'd1);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        tick();
        chk("pri_hold_valid", {7'd0, gnt_valid}, 8'd1);
        chk("pri_hold_idx", {6'd0, gnt_idx}, 8'd1);
        chk("pri_pending", {4'd0, pending}, 8'h0b);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        gnt_ready = 1'b1;
        drain("pri_drain", 20);
        tick();
        chk("pri_cnt", gnt_cnt, 8'd3);
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        chk("b2b_idx", {6'd0, gnt_idx}, 8'd2);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd2);
        gnt_ready = 1'b1;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("b2b_keep", {4'd0, pending}, 8'h04);
        chk("b2b_drop", {4'd0, drop}, 8'd0);
        drain("b2b_drain", 10);
        tick();
        chk("b2b_cnt", gnt_cnt, 8'd2);
        chk("b2b_drop2", {4'd0, drop}, 8'd0);
    endtask

    task automatic test_drop_wrap();
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        tick();
        chk("drp_set", {4'd0, drop}, 8'h01);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        chk("drp_clr", {4'd0, drop}, 8'd0);
        req = 4'b0001;
        drop_clr = 1'b1;
        tick();
        req = 4'b0000;
        drop_clr = 1'b0;
        chk("drp_setwins", {4'd0, drop}, 8'h01);
        drop_clr = 1'b1;
        tick();
        drop_clr = 1'b0;
        gnt_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(2'd0);
            drain("wrap_drain", 8);
            if (i == 254) chk("wrap_ff", gnt_cnt, 8'hff);
            if (i < 255) begin
                req = 4'b0001;
                tick();
                req = 4'b0000;
            end
        end
        chk("wrap_zero", gnt_cnt, 8'd0);
        chk("wrap_pend", {4'd0, pending}, 8'd0);
    endtask

`ifdef REQ_MASK_EN
    task automatic test_mask();
        do_reset();
        mask = 4'b1000;
        req  = 4'b1001;
        tick();
        req  = 4'b0000;
        tick();
        chk("msk_idx0", {6'd0, gnt_idx}, 8'd0);
        exp_q.push_back(2'd0);
        gnt_ready = 1'b1;
        drain("msk_drain0", 6);
        gnt_ready = 1'b0;
        tick();
        tick();
        chk("msk_pend", {4'd0, pending}, 8'h08);
        chk("msk_hidden", {7'd0, gnt_valid}, 8'd0);
        mask = 4'b0000;
        tick();
        tick();
        chk("msk_idx3", {6'd0, gnt_idx}, 8'd3);
        mask = 4'b1000;
        tick();
        chk("msk_nowd", {7'd0, gnt_valid}, 8'd1);
        exp_q.push_back(2'd3);
        gnt_ready = 1'b1;
        drain("msk_drain3", 6);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_drop_wrap();
`ifdef REQ_MASK_EN
        test_mask();
`endif
        gnt_ready = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
